iir_biquad_stage: RTL and testbench

//  Second-order IIR section (direct form I). Sits directly downstream of fractional_decimator.

---
 rtl/iir_biquad_stage.sv | 128 ++++++++++++
 tb/tb_iir_biquad_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_biquad_stage.sv
// Direct-form-I biquad section on a Q1.15 sample stream with Q2.18 coefficients.
// One registered output per valid_in edge, with rounding, saturation and a bypass path.
module iir_biquad_stage #(
   parameter int DATA_WIDTH  = 16,
   parameter int DATA_FRAC   = 15,
   parameter int COEFF_WIDTH = 20,
   parameter int COEFF_FRAC  = 18,
   parameter int ACC_WIDTH   = 40
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                valid_in,
   input  logic [DATA_WIDTH-1:0]               filter_in,
   input  logic                                bypass,
   input  logic                                coeff_wr_en,
   input  logic [4:0][COEFF_WIDTH-1:0]         coeff_data_in,
   output logic [4:0][COEFF_WIDTH-1:0]         coeff_data_out,
   output logic [DATA_WIDTH-1:0]               filter_out,
   output logic                                valid_out,
   output logic                                overflow,
   output logic                                underflow
);

   localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;
   localparam int PROD_FRAC  = DATA_FRAC + COEFF_FRAC;
   localparam int SHIFT      = PROD_FRAC - DATA_FRAC;

   localparam logic [COEFF_WIDTH-1:0] COEFF_ONE = COEFF_WIDTH'(1) << COEFF_FRAC;
   localparam logic signed [ACC_WIDTH-1:0] RND_HALF = ACC_WIDTH'(1) << (SHIFT - 1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   logic [4:0][COEFF_WIDTH-1:0] r_coeff;
   logic signed [DATA_WIDTH-1:0] r_x1, r_x2, r_y1, r_y2;
   logic [DATA_WIDTH-1:0]        r_y;
   logic                         r_valid, r_ovf, r_unf;

   logic signed [DATA_WIDTH-1:0] w_tap  [5];
   logic signed [PROD_WIDTH-1:0] w_prod [5];
   logic signed [ACC_WIDTH-1:0]  w_ext  [5];
   logic signed [ACC_WIDTH-1:0]  w_acc, w_rnd, w_shift;
   logic [DATA_WIDTH-1:0]        w_y_sat;
   logic                         w_ovf, w_unf;

   // Tap order matches the coefficient order {b0,b1,b2,a1,a2}.
   assign w_tap[0] = $signed(filter_in);
   assign w_tap[1] = r_x1;
   assign w_tap[2] = r_x2;
   assign w_tap[3] = r_y1;
   assign w_tap[4] = r_y2;

   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_tap
         assign w_prod[gi] = w_tap[gi] * $signed(r_coeff[gi]);
         assign w_ext[gi]  = {{(ACC_WIDTH-PROD_WIDTH){w_prod[gi][PROD_WIDTH-1]}}, w_prod[gi]};
      end
   endgenerate

   assign w_acc   = w_ext[0] + w_ext[1] + w_ext[2] - w_ext[3] - w_ext[4];
   assign w_rnd   = w_acc + RND_HALF;
   assign w_shift = w_rnd >>> SHIFT;

   always_comb begin
      w_ovf   = 1'b0;
      w_unf   = 1'b0;
      w_y_sat = w_shift[DATA_WIDTH-1:0];
      if (w_shift > SAT_MAX) begin
         w_ovf   = 1'b1;
         w_y_sat = SAT_MAX[DATA_WIDTH-1:0];
      end else if (w_shift < SAT_MIN) begin
         w_unf   = 1'b1;
         w_y_sat = SAT_MIN[DATA_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_coeff    <= '0;
         r_coeff[0] <= COEFF_ONE;
         r_x1       <= '0;
         r_x2       <= '0;
         r_y1       <= '0;
         r_y2       <= '0;
         r_y        <= '0;
         r_valid    <= 1'b0;
         r_ovf      <= 1'b0;
         r_unf      <= 1'b0;
      end else begin
         r_valid <= valid_in;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
         if (valid_in) begin
            if (bypass) begin
               r_y <= filter_in;
            end else begin
               r_y   <= w_y_sat;
               r_ovf <= w_ovf;
               r_unf <= w_unf;
            end
         end
         // A coefficient load wins over the history shift; the sample above still used the old set.
         if (coeff_wr_en || (valid_in && bypass)) begin
            r_x1 <= '0;
            r_x2 <= '0;
            r_y1 <= '0;
            r_y2 <= '0;
         end else if (valid_in) begin
            r_x2 <= r_x1;
            r_x1 <= $signed(filter_in);
            r_y2 <= r_y1;
            r_y1 <= $signed(w_y_sat);
         end
         if (coeff_wr_en) begin
            r_coeff <= coeff_data_in;
         end
      end
   end

   assign coeff_data_out = r_coeff;
   assign filter_out     = r_y;
   assign valid_out      = r_valid;
   assign overflow       = r_ovf;
   assign underflow      = r_unf;

endmodule

// File: tb/tb_iir_biquad_stage.sv
// Directed bench for iir_biquad_stage: identity, FIR, feedback, saturation, coefficient load,
// bypass with dense valid_in, and asynchronous reset mid-stream.
module tb_iir_biquad_stage;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                valid_in = 1'b0;
   logic [15:0]         filter_in = '0;
   logic                bypass = 1'b0;
   logic                coeff_wr_en = 1'b0;
   logic [4:0][19:0]    coeff_data_in = '0;
   logic [4:0][19:0]    coeff_data_out;
   logic [15:0]         filter_out;
   logic                valid_out;
   logic                overflow;
   logic                underflow;

   int checks = 0;
   int failures = 0;

   iir_biquad_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .valid_in       (valid_in),
      .filter_in      (filter_in),
      .bypass         (bypass),
      .coeff_wr_en    (coeff_wr_en),
      .coeff_data_in  (coeff_data_in),
      .coeff_data_out (coeff_data_out),
      .filter_out     (filter_out),
      .valid_out      (valid_out),
      .overflow       (overflow),
      .underflow      (underflow)
   );

   always #5 clk = ~clk;

   // One valid sample; outputs are observed 1 ns after the edge that registers it.
   task automatic send(input logic [15:0] x);
      filter_in = x;
      valid_in  = 1'b1;
      @(posedge clk);
      #1;
      valid_in  = 1'b0;
   endtask

   task automatic load(input logic [19:0] b0, input logic [19:0] b1, input logic [19:0] b2,
                       input logic [19:0] a1, input logic [19:0] a2);
      coeff_data_in = {a2, a1, b2, b1, b0};
      coeff_wr_en   = 1'b1;
      @(posedge clk);
      #1;
      coeff_wr_en   = 1'b0;
   endtask

   task automatic test_reset();
      logic [4:0][19:0] exp_c;
      exp_c = {20'd0, 20'd0, 20'd0, 20'd0, 20'd262144};
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({filter_out, valid_out, overflow, underflow} !== 19'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%h/%b/%b/%b want=0000/0/0/0", filter_out, valid_out, overflow, underflow);
      end
      checks++;
      if (coeff_data_out !== exp_c) begin
         failures++;
         $display("FAIL reset_coeffs got=%h want=%h", coeff_data_out, exp_c);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(16'h4000);
      checks++;
      if (filter_out !== 16'h4000 || valid_out !== 1'b1) begin
         failures++;
         $display("FAIL reset_identity0 got=%h v=%b want=4000 v=1", filter_out, valid_out);
      end
      send(16'h8001);
      checks++;
      if (filter_out !== 16'h8001 || valid_out !== 1'b1 || underflow !== 1'b0) begin
         failures++;
         $display("FAIL reset_identity1 got=%h v=%b u=%b want=8001 v=1 u=0", filter_out, valid_out, underflow);
      end
      @(posedge clk);
      #1;
      checks++;
      if (filter_out !== 16'h8001 || valid_out !== 1'b0) begin
         failures++;
         $display("FAIL idle_hold got=%h v=%b want=8001 v=0", filter_out, valid_out);
      end
      $display("test_reset done");
   endtask

   task automatic test_fir();
      logic [15:0] exp_y [4];
      exp_y = '{16'h1000, 16'h1000, 16'h1000, 16'h0000};
      load(20'd65536, 20'd65536, 20'd65536, 20'd0, 20'd0);
      checks++;
      if (coeff_data_out !== {20'd0, 20'd0, 20'd65536, 20'd65536, 20'd65536}) begin
         failures++;
         $display("FAIL fir_coeffs got=%h", coeff_data_out);
      end
      for (int i = 0; i < 4; i++) begin
         send(i == 0 ? 16'h4000 : 16'h0000);
         checks++;
         if (filter_out !== exp_y[i] || valid_out !== 1'b1) begin
            failures++;
            $display("FAIL fir_out%0d got=%h want=%h", i, filter_out, exp_y[i]);
         end
      end
      $display("test_fir done");
   endtask

   task automatic test_feedback();
      logic [15:0] exp_y [5];
      exp_y = '{16'h4000, 16'h2000, 16'h1000, 16'h0800, 16'h0400};
      load(20'd262144, 20'd0, 20'd0, 20'hE0000, 20'd0);
      for (int i = 0; i < 5; i++) begin
         send(i == 0 ? 16'h4000 : 16'h0000);
         checks++;
         if (filter_out !== exp_y[i]) begin
            failures++;
            $display("FAIL feedback_out%0d got=%h want=%h", i, filter_out, exp_y[i]);
         end
      end
      $display("test_feedback done");
   endtask

   task automatic test_saturation();
      load(20'd393216, 20'd0, 20'd0, 20'd0, 20'd0);
      send(16'h7000);
      checks++;
      if (filter_out !== 16'h7FFF || overflow !== 1'b1 || underflow !== 1'b0) begin
         failures++;
         $display("FAIL sat_pos got=%h o=%b u=%b want=7fff o=1 u=0", filter_out, overflow, underflow);
      end
      send(16'h9000);
      checks++;
      if (filter_out !== 16'h8000 || overflow !== 1'b0 || underflow !== 1'b1) begin
         failures++;
         $display("FAIL sat_neg got=%h o=%b u=%b want=8000 o=0 u=1", filter_out, overflow, underflow);
      end
      send(16'h1000);
      checks++;
      if (filter_out !== 16'h1800 || overflow !== 1'b0 || underflow !== 1'b0) begin
         failures++;
         $display("FAIL sat_none got=%h o=%b u=%b want=1800 o=0 u=0", filter_out, overflow, underflow);
      end
      $display("test_saturation done");
   endtask

   task automatic test_coeff_midstream();
      load(20'd262144, 20'd0, 20'd0, 20'hE0000, 20'd0);
      send(16'h4000);
      send(16'h0000);
      checks++;
      if (filter_out !== 16'h2000) begin
         failures++;
         $display("FAIL mid_out1 got=%h want=2000", filter_out);
      end
      // New set is identity; the sample on this edge must still use the feedback set.
      coeff_data_in = {20'd0, 20'd0, 20'd0, 20'd0, 20'd262144};
      coeff_wr_en   = 1'b1;
      send(16'h0000);
      coeff_wr_en   = 1'b0;
      checks++;
      if (filter_out !== 16'h1000 || valid_out !== 1'b1) begin
         failures++;
         $display("FAIL mid_out2 got=%h v=%b want=1000 v=1", filter_out, valid_out);
      end
      for (int i = 0; i < 2; i++) begin
         send(16'h0000);
         checks++;
         if (filter_out !== 16'h0000) begin
            failures++;
            $display("FAIL mid_zero%0d got=%h want=0000", i, filter_out);
         end
      end
      send(16'h0123);
      checks++;
      if (filter_out !== 16'h0123) begin
         failures++;
         $display("FAIL mid_newset got=%h want=0123", filter_out);
      end
      $display("test_coeff_midstream done");
   endtask

   task automatic test_back_to_back();
      logic [15:0] prev;
      logic [15:0] exp_y [5];
      logic        v;
      int          n_in, n_out, bad;
      exp_y = '{16'h4000, 16'h2000, 16'h1000, 16'h0800, 16'h0400};
      load(20'd262144, 20'd0, 20'd0, 20'hE0000, 20'd0);
      // Leave non-zero history behind so the bypass clear is visible afterwards.
      send(16'h4000);
      send(16'h3000);
      bypass = 1'b1;
      n_in = 0; n_out = 0; bad = 0; prev = '0;
      for (int i = 0; i < 60; i++) begin
         v = (i < 30) ? ((i % 3) != 2) : 1'b1;
         valid_in  = v;
         filter_in = 16'($urandom);
         if (v) begin
            n_in++;
            prev = filter_in;
         end
         @(posedge clk);
         #1;
         if (valid_out) n_out++;
         if (valid_out !== v || (v && filter_out !== prev) || overflow !== 1'b0 || underflow !== 1'b0) begin
            bad++;
            if (bad == 1)
               $display("FAIL bypass_cycle%0d got=%h v=%b want=%h v=%b", i, filter_out, valid_out, prev, v);
         end
      end
      valid_in = 1'b0;
      bypass   = 1'b0;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL bypass_stream mismatched_cycles=%0d want=0", bad);
      end
      checks++;
      if (n_out != n_in) begin
         failures++;
         $display("FAIL bypass_count got=%0d want=%0d", n_out, n_in);
      end
      for (int i = 0; i < 5; i++) begin
         send(i == 0 ? 16'h4000 : 16'h0000);
         checks++;
         if (filter_out !== exp_y[i]) begin
            failures++;
            $display("FAIL post_bypass_out%0d got=%h want=%h", i, filter_out, exp_y[i]);
         end
      end
      $display("test_back_to_back done in=%0d out=%0d", n_in, n_out);
   endtask

   task automatic test_reset_midstream();
      load(20'd65536, 20'd0, 20'd0, 20'd0, 20'd0);
      send(16'h4000);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (filter_out !== 16'h0000 || valid_out !== 1'b0 ||
          coeff_data_out !== {20'd0, 20'd0, 20'd0, 20'd0, 20'd262144}) begin
         failures++;
         $display("FAIL async_reset got=%h v=%b c=%h", filter_out, valid_out, coeff_data_out);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(16'h0456);
      send(16'h0000);
      checks++;
      if (filter_out !== 16'h0000) begin
         failures++;
         $display("FAIL post_reset_history got=%h want=0000", filter_out);
      end
      $display("test_reset_midstream done");
   endtask

   initial begin
      test_reset();
      test_fir();
      test_feedback();
      test_saturation();
      test_coeff_midstream();
      test_back_to_back();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "simulation time limit reached");
   end

endmodule
